reg_file_mp: RTL and testbench

Parametrised multi-port register file for the next-generation single-cycle/pipelined CPU datapath. Replaces the fixed 8x8, one-write/two-read file:
- configurable width, depth and read-port count;
- second write port;
- optional write-to-read bypass and hardwired-zero register 0;
- per-register busy scoreboard so the control unit can detect pending writes.

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_rd_port.sv | 33 +++
 rtl/reg_file_mp.sv | 72 +++++++
 tb/tb_reg_file_mp.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file constants and write-collision decode.
// Default geometry constants and the write-port winner decode are also used by the CPU control unit.
package reg_file_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_RD = 2;
  typedef enum logic [1:0] {WR_NONE, WR_P0, WR_P1} wr_sel_e;
  // Port 1 wins when both write ports target the same register.
  function automatic wr_sel_e wr_winner(input logic hit0, input logic hit1);
    return hit1 ? WR_P1 : hit0 ? WR_P0 : WR_NONE;
  endfunction
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read lane with optional write bypass and zero register.
// Ports: regs/busy = full storage and scoreboard; raddr = lane address;
// we0/waddr0/wdata0, we1/waddr1/wdata1 = write ports (for bypass); rdata/rbusy = lane outputs.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [2**ADDR_W-1:0]             busy,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic                             we0,
  input  logic [ADDR_W-1:0]                waddr0,
  input  logic [DATA_W-1:0]                wdata0,
  input  logic                             we1,
  input  logic [ADDR_W-1:0]                waddr1,
  input  logic [DATA_W-1:0]                wdata1,
  output logic [DATA_W-1:0]                rdata,
  output logic                             rbusy
);
  wr_sel_e sel;
  logic    zero;
  // A bypassed write is by definition no longer pending, so it reports not-busy.
  always_comb begin
    sel   = wr_winner(BYPASS != 0 && we0 && waddr0 == raddr, BYPASS != 0 && we1 && waddr1 == raddr);
    zero  = ZERO_REG != 0 && raddr == '0;
    rdata = zero ? '0 : sel == WR_P1 ? wdata1 : sel == WR_P0 ? wdata0 : regs[raddr];
    rbusy = !zero && sel == WR_NONE && busy[raddr];
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised two-write, multi-read register file with busy scoreboard.
// Ports: CLK/RESET (sync, active-high); WE0/WADDR0/WDATA0 and WE1/WADDR1/WDATA1 write ports (port 1 wins);
// RADDR/RDATA/RBUSY packed read lanes; ISSUE_EN/ISSUE_ADDR mark a register busy; ANY_BUSY = OR of busy bits.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WADDR0,
  input  logic [DATA_W-1:0]        WDATA0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WADDR1,
  input  logic [DATA_W-1:0]        WDATA1,
  input  logic [NUM_RD*ADDR_W-1:0] RADDR,
  output logic [NUM_RD*DATA_W-1:0] RDATA,
  output logic [NUM_RD-1:0]        RBUSY,
  input  logic                     ISSUE_EN,
  input  logic [ADDR_W-1:0]        ISSUE_ADDR,
  output logic                     ANY_BUSY
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  wr_sel_e                      sel [DEPTH];
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      sel[i] = wr_winner(WE0 && WADDR0 == ADDR_W'(i), WE1 && WADDR1 == ADDR_W'(i));
  end
  // Register 0 is never updated when hardwired to zero, so it stays at its reset value.
  // An issue in the same cycle as a write models a newer pending write, so it wins the busy bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG != 0 && i == 0)) begin
          regs[i] <= sel[i] == WR_P1 ? WDATA1 : sel[i] == WR_P0 ? WDATA0 : regs[i];
          busy[i] <= (ISSUE_EN && ISSUE_ADDR == ADDR_W'(i)) || (sel[i] == WR_NONE && busy[i]);
        end
      end
    end
  end
  assign ANY_BUSY = |busy;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .regs  (regs),
      .busy  (busy),
      .raddr (RADDR[k*ADDR_W +: ADDR_W]),
      .we0   (WE0),
      .waddr0(WADDR0),
      .wdata0(WDATA0),
      .we1   (WE1),
      .waddr1(WADDR1),
      .wdata1(WDATA1),
      .rdata (RDATA[k*DATA_W +: DATA_W]),
      .rbusy (RBUSY[k])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized and directed checks of three reg_file_mp variants against an array model.
module tb_reg_file_mp;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 2;
  localparam int D  = 8;
  localparam int NV = 3;
  logic          CLK = 1'b0;
  logic          RESET;
  logic          we0, we1, issue_en;
  logic [AW-1:0] wa0, wa1, ia;
  logic [DW-1:0] wd0, wd1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata [NV];
  logic [NR-1:0]    rbusy [NV];
  logic             any_busy [NV];
  logic [DW-1:0]    mreg [NV][D];
  logic             mbusy [NV][D];
  bit               valid = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  always #5 CLK = ~CLK;
  // variant 0: bypass, no zero reg; variant 1: no bypass; variant 2: bypass + zero reg
  for (genvar v = 0; v < NV; v++) begin : g_dut
    reg_file_mp #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
      .BYPASS(v == 1 ? 0 : 1), .ZERO_REG(v == 2 ? 1 : 0)
    ) dut (
      .CLK(CLK), .RESET(RESET),
      .WE0(we0), .WADDR0(wa0), .WDATA0(wd0),
      .WE1(we1), .WADDR1(wa1), .WDATA1(wd1),
      .RADDR(raddr), .RDATA(rdata[v]), .RBUSY(rbusy[v]),
      .ISSUE_EN(issue_en), .ISSUE_ADDR(ia), .ANY_BUSY(any_busy[v])
    );
  end
  function automatic bit byp(int v);
    return v != 1;
  endfunction
  function automatic bit zr(int v);
    return v == 2;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    RESET = 0; we0 = 0; we1 = 0; issue_en = 0;
    wa0 = '0; wa1 = '0; ia = '0; wd0 = '0; wd1 = '0;
  endtask
  task automatic sample(input string tag);
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          eb, ea;
    @(negedge CLK);
    if (valid) begin
      for (int v = 0; v < NV; v++) begin
        for (int k = 0; k < NR; k++) begin
          a = raddr[k*AW +: AW];
          if (zr(v) && a == 0) begin ed = 0; eb = 0; end
          else if (byp(v) && we1 && wa1 == a) begin ed = wd1; eb = 0; end
          else if (byp(v) && we0 && wa0 == a) begin ed = wd0; eb = 0; end
          else begin ed = mreg[v][a]; eb = mbusy[v][a]; end
          chk($sformatf("%s v%0d rdata%0d", tag, v, k), 32'(rdata[v][k*DW +: DW]), 32'(ed));
          chk($sformatf("%s v%0d rbusy%0d", tag, v, k), 32'(rbusy[v][k]), 32'(eb));
        end
        ea = 0;
        for (int r = 0; r < D; r++) ea = ea | mbusy[v][r];
        chk($sformatf("%s v%0d any_busy", tag, v), 32'(any_busy[v]), 32'(ea));
      end
    end
  endtask
  task automatic commit();
    @(posedge CLK);
    for (int v = 0; v < NV; v++) begin
      if (RESET) begin
        for (int r = 0; r < D; r++) begin mreg[v][r] = 0; mbusy[v][r] = 0; end
      end else if (valid) begin
        if (we0 && !(zr(v) && wa0 == 0)) begin mreg[v][wa0] = wd0; mbusy[v][wa0] = 0; end
        if (we1 && !(zr(v) && wa1 == 0)) begin mreg[v][wa1] = wd1; mbusy[v][wa1] = 0; end
        if (issue_en && !(zr(v) && ia == 0)) mbusy[v][ia] = 1;
      end
    end
    if (RESET) valid = 1;
    #1;
  endtask
  initial begin
    idle();
    raddr = '0;
    RESET = 1;
    sample("init"); commit();
    idle();
    for (int a = 0; a < D; a++) begin
      we0 = 1; wa0 = AW'(a); wd0 = DW'($urandom);
      we1 = 1; wa1 = AW'($urandom); wd1 = DW'($urandom);
      issue_en = 1; ia = AW'($urandom);
      raddr = NR*AW'($urandom);
      sample("fill"); commit();
    end
    idle();
    RESET = 1; we0 = 1; wa0 = 3; wd0 = 8'h5A; issue_en = 1; ia = 4;
    sample("rst_cycle"); commit();
    idle();
    for (int a = 0; a < D; a += 2) begin
      raddr = {AW'(a + 1), AW'(a)};
      sample("after_rst");
      chk("rst_zero", 32'(rdata[0]), 0);
      chk("rst_rbusy", 32'(rbusy[0]), 0);
      chk("rst_any", 32'(any_busy[0]), 0);
      commit();
    end
    we0 = 1; wa0 = 3; wd0 = DW'(-23);
    sample("basic_wr"); commit();
    idle(); raddr = {AW'(6), AW'(3)};
    sample("basic_rd");
    chk("basic", 32'(rdata[0][DW-1:0]), 32'h0E9);
    chk("untouched6", 32'(rdata[0][2*DW-1:DW]), 0);
    commit();
    we0 = 1; wa0 = 2; wd0 = 20; we1 = 1; wa1 = 2; wd1 = 45;
    sample("coll_wr"); commit();
    idle(); raddr = {AW'(2), AW'(2)};
    sample("coll_rd");
    chk("collision", 32'(rdata[0][DW-1:0]), 45);
    commit();
    raddr = {AW'(7), AW'(0)}; we1 = 1; wa1 = 7; wd1 = 12;
    sample("byp_wr");
    chk("bypass_on", 32'(rdata[0][2*DW-1:DW]), 12);
    chk("bypass_off_old", 32'(rdata[1][2*DW-1:DW]), 0);
    commit();
    idle();
    sample("byp_rd");
    chk("bypass_off_new", 32'(rdata[1][2*DW-1:DW]), 12);
    commit();
    issue_en = 1; ia = 5;
    sample("issue"); commit();
    idle(); raddr = {AW'(5), AW'(5)};
    sample("busy_rd");
    chk("busy_set", 32'(rbusy[0]), 3);
    chk("busy_any", 32'(any_busy[0]), 1);
    commit();
    we0 = 1; wa0 = 5; wd0 = 8'h33;
    sample("clr_wr"); commit();
    idle();
    sample("clr_rd");
    chk("busy_clr", 32'(rbusy[0]), 0);
    chk("busy_clr_any", 32'(any_busy[0]), 0);
    commit();
    we0 = 1; wa0 = 5; wd0 = 8'h77; issue_en = 1; ia = 5;
    sample("iss_wr"); commit();
    idle();
    sample("iss_wr_rd");
    chk("iss_wr_busy", 32'(rbusy[0]), 3);
    chk("iss_wr_data", 32'(rdata[0][DW-1:0]), 32'h77);
    commit();
    we0 = 1; wa0 = 0; wd0 = 8'hFF; issue_en = 1; ia = 0; we1 = 1; wa1 = 5; wd1 = 8'h44;
    sample("zero_wr"); commit();
    idle(); raddr = {AW'(0), AW'(0)};
    sample("zero_rd");
    chk("zero_data", 32'(rdata[2]), 0);
    chk("zero_rbusy", 32'(rbusy[2]), 0);
    chk("zero_any", 32'(any_busy[2]), 0);
    chk("nonzero_data", 32'(rdata[0][DW-1:0]), 32'hFF);
    chk("nonzero_any", 32'(any_busy[0]), 1);
    commit();
    for (int n = 0; n < 400; n++) begin
      RESET = $urandom_range(0, 49) == 0;
      we0 = 1'($urandom); wa0 = AW'($urandom); wd0 = DW'($urandom);
      we1 = 1'($urandom); wa1 = $urandom_range(0, 3) == 0 ? wa0 : AW'($urandom); wd1 = DW'($urandom);
      issue_en = 1'($urandom); ia = $urandom_range(0, 3) == 0 ? wa0 : AW'($urandom);
      raddr = $urandom_range(0, 2) == 0 ? {wa1, wa0} : NR*AW'($urandom);
      sample("rand"); commit();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
